// File: rtl/wave_mode_sequencer.sv
// Front-panel waveform selector for the DDS: debounced mode key, commit on phase wrap.
// Optional auto-scan stepping is built when AUTO_SCAN_EN is defined.
module wave_mode_sequencer #(
    parameter int DEB_W        = 20,
    parameter int DEB_MAX      = 999999,
    parameter int TO_W         = 24,
    parameter int WRAP_TIMEOUT = 5000000,
    parameter int SCAN_PERIODS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_scan,
    input  logic       phase_wrap,
    output logic [1:0] OutMode,
    output logic       mode_pending,
    output logic       scan_active
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

`ifdef AUTO_SCAN_EN
    localparam int NK = 2;
`else
    localparam int NK = 1;
`endif

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(WRAP_TIMEOUT);

    logic [NK-1:0]    key_raw;
    logic [NK-1:0]    sync1_q, sync1_d;
    logic [NK-1:0]    sync2_q, sync2_d;
    logic [NK-1:0]    stable_q, stable_d;
    logic [NK-1:0]    press_q, press_d;
    logic [DEB_W-1:0] deb_cnt_q [NK];
    logic [DEB_W-1:0] deb_cnt_d [NK];

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      next_q, next_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            pending_q, pending_d;
    logic            mode_press;

`ifdef AUTO_SCAN_EN
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_PERIODS - 1);

    logic        scan_q, scan_d;
    logic [15:0] wraps_q, wraps_d;
    logic        scan_press;

    assign key_raw     = {key_scan, key_mode};
    assign scan_press  = press_q[1];
    assign scan_active = scan_q;
`else
    logic unused_scan_key;

    assign key_raw         = key_mode;
    assign unused_scan_key = key_scan;
    assign scan_active     = 1'b0;
`endif

    assign mode_press   = press_q[0];
    assign OutMode      = mode_q;
    assign mode_pending = pending_q;

    // A key level is accepted after DEB_MAX consecutive synced cycles that differ
    // from the stable level; only the released-to-pressed edge emits a pulse.
    always_comb begin
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = '0;
        for (int k = 0; k < NK; k++) begin
            deb_cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (deb_cnt_q[k] == DEB_LAST) begin
                    stable_d[k] = sync2_q[k];
                    press_d[k]  = ~sync2_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        next_d   = next_q;
        to_cnt_d = to_cnt_q;

        if (state_q == IDLE) begin
            if (mode_press) begin
                next_d   = mode_q + 2'd1;
                to_cnt_d = '0;
                state_d  = PENDING;
            end
        end else begin
            // A press landing on the commit cycle is folded into the committed mode.
            if (phase_wrap || (to_cnt_q == TO_LAST)) begin
                mode_d  = next_q + {1'b0, mode_press};
                state_d = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (mode_press) begin
                    next_d = next_q + 2'd1;
                end
            end
        end

`ifdef AUTO_SCAN_EN
        scan_d  = scan_q;
        wraps_d = wraps_q;
        if (mode_press) begin
            scan_d = 1'b0;
        end else if (scan_press) begin
            scan_d  = ~scan_q;
            wraps_d = '0;
        end else if (scan_q && phase_wrap && (state_q == IDLE)) begin
            if (wraps_q == SCAN_LAST) begin
                mode_d  = mode_q + 2'd1;
                wraps_d = '0;
            end else begin
                wraps_d = wraps_q + 16'd1;
            end
        end
`endif

        pending_d = (state_d == PENDING);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '1;
            press_q  <= '0;
            for (int k = 0; k < NK; k++) begin
                deb_cnt_q[k] <= '0;
            end
            state_q   <= IDLE;
            mode_q    <= 2'b01;
            next_q    <= 2'b01;
            to_cnt_q  <= '0;
            pending_q <= 1'b0;
`ifdef AUTO_SCAN_EN
            scan_q  <= 1'b0;
            wraps_q <= '0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int k = 0; k < NK; k++) begin
                deb_cnt_q[k] <= deb_cnt_d[k];
            end
            state_q   <= state_d;
            mode_q    <= mode_d;
            next_q    <= next_d;
            to_cnt_q  <= to_cnt_d;
            pending_q <= pending_d;
`ifdef AUTO_SCAN_EN
            scan_q  <= scan_d;
            wraps_q <= wraps_d;
`endif
        end
    end

endmodule

// File: tb/tb_wave_mode_sequencer.sv
// Scoreboard bench for wave_mode_sequencer: randomized key/wrap stimulus against an
// event-level model of the mode rules; a monitor compares the outputs every cycle.
module tb_wave_mode_sequencer;

    localparam int DEB_MAX      = 15;
    localparam int WRAP_TIMEOUT = 120;
    localparam int SCAN_PERIODS = 4;
    // Key driven low before edge c is acted on by the mode logic at edge c+PRESS_LAT:
    // two synchroniser stages, DEB_MAX stable cycles, then the registered press pulse.
    localparam int PRESS_LAT    = DEB_MAX + 2;
`ifdef AUTO_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif
    localparam logic [3:0] RESET_OUTS = {2'b01, 1'b0, 1'b0};

    logic       clk;
    logic       reset;
    logic       key_mode;
    logic       key_scan;
    logic       phase_wrap;
    logic [1:0] OutMode;
    logic       mode_pending;
    logic       scan_active;

    wave_mode_sequencer #(
        .DEB_W(20),
        .DEB_MAX(DEB_MAX),
        .TO_W(24),
        .WRAP_TIMEOUT(WRAP_TIMEOUT),
        .SCAN_PERIODS(SCAN_PERIODS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_mode(key_mode),
        .key_scan(key_scan),
        .phase_wrap(phase_wrap),
        .OutMode(OutMode),
        .mode_pending(mode_pending),
        .scan_active(scan_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_q[$];
    int         exp_cyc_q[$];

    int cyc;
    int force_wrap_cycle;
    int wrap_period;
    int wrap_prob;
    bit mode_press_at[int];
    bit scan_press_at[int];

    logic [1:0] m_mode;
    logic [1:0] m_next;
    bit         m_pending;
    bit         m_scan;
    int         m_entry;
    int         m_wraps;

    function automatic logic [3:0] dut_outs();
        return {OutMode, mode_pending, scan_active};
    endfunction

    task automatic check_output(input string name, input int at, input logic [3:0] want,
                                input logic [3:0] got);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got mode=%b pend=%b scan=%b, want mode=%b pend=%b scan=%b",
                     name, at, got[3:2], got[1], got[0], want[3:2], want[1], want[0]);
        end
    endtask

    task automatic model_reset();
        m_mode    = 2'b01;
        m_next    = 2'b01;
        m_pending = 1'b0;
        m_scan    = 1'b0;
        m_entry   = 0;
        m_wraps   = 0;
        mode_press_at.delete();
        scan_press_at.delete();
        force_wrap_cycle = -1;
    endtask

    // Applies the mode/scan rules for one clock edge given that edge's events.
    task automatic model_step(input bit pw, input bit mp, input bit sp);
        bit was_idle;
        was_idle = !m_pending;
        if (was_idle) begin
            if (mp) begin
                m_next    = m_mode + 2'd1;
                m_pending = 1'b1;
                m_entry   = cyc;
            end
        end else if (pw || (cyc - m_entry == WRAP_TIMEOUT + 1)) begin
            m_mode    = mp ? m_next + 2'd1 : m_next;
            m_pending = 1'b0;
        end else if (mp) begin
            m_next = m_next + 2'd1;
        end

        if (SCAN_EN) begin
            if (mp) begin
                m_scan = 1'b0;
            end else if (sp) begin
                m_scan  = !m_scan;
                m_wraps = 0;
            end else if (m_scan && pw && was_idle) begin
                m_wraps++;
                if (m_wraps == SCAN_PERIODS) begin
                    m_mode  = m_mode + 2'd1;
                    m_wraps = 0;
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic km, input logic ks);
        bit pw;
        @(negedge clk);
        pw = (cyc == force_wrap_cycle) ||
             ((wrap_period != 0) && (cyc % wrap_period == 0)) ||
             ($urandom_range(0, 99) < wrap_prob);
        key_mode   = km;
        key_scan   = ks;
        phase_wrap = pw;
        model_step(pw, mode_press_at.exists(cyc), scan_press_at.exists(cyc));
        exp_q.push_back({m_mode, m_pending, m_scan});
        exp_cyc_q.push_back(cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b1, 1'b1);
    endtask

    task automatic hold_key(input bit is_scan, input logic level, input int n);
        repeat (n) apply_stimulus(is_scan ? 1'b1 : level, is_scan ? level : 1'b1);
    endtask

    // Optional short bounces, then one clean press and release; wrap_delay >= 0 forces
    // a phase_wrap that many cycles after the press reaches the mode logic.
    task automatic do_press(input bit is_scan, input int nglitch, input int wrap_delay);
        for (int g = 0; g < nglitch; g++) begin
            hold_key(is_scan, 1'b0, $urandom_range(1, 5));
            hold_key(is_scan, 1'b1, $urandom_range(2, 8));
        end
        if (is_scan) scan_press_at[cyc + PRESS_LAT] = 1'b1;
        else         mode_press_at[cyc + PRESS_LAT] = 1'b1;
        if (wrap_delay >= 0) force_wrap_cycle = cyc + PRESS_LAT + wrap_delay;
        hold_key(is_scan, 1'b0, $urandom_range(DEB_MAX + 5, DEB_MAX + 8));
        hold_key(is_scan, 1'b1, $urandom_range(DEB_MAX + 5, DEB_MAX + 8));
    endtask

    task automatic pulse_reset_async();
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_output("async_reset", cyc, RESET_OUTS, dut_outs());
        @(negedge clk);
        check_output("reset_hold", cyc, RESET_OUTS, dut_outs());
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check_output("outputs", exp_cyc_q.pop_front(), exp_q.pop_front(), dut_outs());
        end
    end

    initial begin
        reset       = 1'b0;
        key_mode    = 1'b1;
        key_scan    = 1'b1;
        phase_wrap  = 1'b0;
        cyc         = 0;
        wrap_period = 0;
        wrap_prob   = 0;
        model_reset();

        repeat (2) @(negedge clk);
        #1 check_output("reset_state", cyc, RESET_OUTS, dut_outs());
        @(negedge clk);
        reset = 1'b1;

        idle(100);

        wrap_period = 40;
        do_press(1'b0, 3, -1);
        idle(60);

        wrap_period = 0;
        do_press(1'b0, 0, -1);
        do_press(1'b0, 0, -1);
        do_press(1'b0, 0, 3);
        idle(20);

        do_press(1'b0, 0, -1);
        do_press(1'b0, 0, 0);
        idle(20);

        do_press(1'b0, 1, -1);
        idle(150);

        do_press(1'b0, 0, -1);
        pulse_reset_async();
        wrap_period = 10;
        idle(50);

        wrap_period = 3;
        do_press(1'b1, 0, -1);
        idle(60);
        do_press(1'b0, 0, -1);
        idle(40);

        wrap_period = 0;
        wrap_prob   = 8;
        repeat (30) begin
            case ($urandom_range(0, 3))
                0, 1:    do_press(1'b0, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 0 : -1);
                2:       do_press(1'b1, $urandom_range(0, 1), -1);
                default: idle($urandom_range(5, 40));
            endcase
        end
        wrap_prob = 0;
        idle(5);

        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wave_mode_sequencer.md
Name: wave_mode_sequencer

Overview:
- Front-panel controller that sequences the DDS output waveform selector.
- Debounces a raw mode key and steps the 2-bit waveform mode.
- Commits each mode change only on a phase-accumulator wrap, so the switch is glitch-free; a timeout covers a stalled accumulator.
- Drives OutMode of the waveform output mux directly.

Parameters:
- DEB_W, 20, debounce counter width.
- DEB_MAX, 999999, stable cycles needed to accept a key level (20 ms at 50 MHz).
- TO_W, 24, wrap-timeout counter width.
- WRAP_TIMEOUT, 5000000, cycles in PENDING without phase_wrap before a forced commit.
- SCAN_PERIODS, 1000, phase wraps per waveform in auto-scan (16-bit).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- key_mode  input  1  raw mode key, active-low, asynchronous to clk
- key_scan  input  1  raw auto-scan key, active-low (used only with AUTO_SCAN_EN)
- phase_wrap  input  1  one-cycle pulse on phase-accumulator overflow
- OutMode  output  2  waveform select: 01 sin, 10 PWM, 11 triangular, 00 rectangle
- mode_pending  output  1  high while a requested change awaits commit
- scan_active  output  1  auto-scan running

Behaviour:
- Reset (reset=0, asynchronous):
  - OutMode=2'b01.
  - mode_pending=0, scan_active=0.
  - Sync and stable key registers=1 (released).
  - All counters=0, FSM=IDLE.
- Key path, per key:
  - 2-flop synchroniser.
  - Debounce: when the synced level differs from the stable level, the counter increments; on reaching DEB_MAX, stable takes the synced level and the counter clears. When the levels match, the counter clears.
  - A press is a stable 1->0 transition and produces a one-cycle internal pulse. Release produces nothing.
- Mode order: 2-bit increment with wrap, 01->10->11->00->01.
- FSM, two states:
  - IDLE:
    - Press -> next_mode=OutMode+1, timeout counter=0, go to PENDING.
    - phase_wrap alone has no effect.
  - PENDING (mode_pending=1):
    - phase_wrap -> OutMode<=next_mode, go to IDLE. OutMode changes on the clock edge that samples phase_wrap, so the new value is visible the cycle after the pulse.
    - Press with no wrap -> next_mode+=1, stay in PENDING (presses accumulate, 2-bit wrap).
    - Press and phase_wrap in the same cycle -> OutMode<=next_mode+1, go to IDLE.
    - Timeout counter reaches WRAP_TIMEOUT with no wrap -> OutMode<=next_mode, go to IDLE (forced commit for frequency word 0).
- mode_pending is registered and equals (state==PENDING).
- phase_wrap held high for several cycles is treated as one pulse per cycle; only the first one in PENDING commits.
- Reset mid-PENDING discards the pending request; OutMode returns to 01.

Optional Feature:
- Macro: AUTO_SCAN_EN.
- Defined:
  - A key_scan press (same debounce path) toggles scan_active. Turning scan on clears the wrap counter.
  - While scan_active=1, each phase_wrap increments a 16-bit wrap counter.
  - On the wrap that brings the count to SCAN_PERIODS, OutMode<=OutMode+1 on that same edge and the counter clears.
  - A mode-key press while scanning clears scan_active and follows the normal IDLE->PENDING path.
  - A scan commit and a PENDING commit never coincide, because a press cancels scan first.
- Undefined:
  - key_scan ignored, scan_active tied to 0.
  - No scan counter logic synthesised.

Test Plan:
- Reset pulse low with no activity -> OutMode=01, mode_pending=0, scan_active=0; hold 100 cycles, no change.
- Bounce key_mode (DEB_MAX=15 for sim) with 5-cycle glitches, then hold low 30 cycles; phase_wrap every 40 cycles -> exactly one press; mode_pending=1 until the next wrap; OutMode=10 the cycle after the wrap.
- Three presses before any wrap -> OutMode jumps 01->00 at the first wrap. A press coincident with a wrap in PENDING -> the extra increment is applied.
- No phase_wrap, one press, WRAP_TIMEOUT=50 -> OutMode=10 51 cycles after PENDING entry; mode_pending drops at the same edge.
- Assert reset while PENDING -> OutMode=01 and mode_pending=0 immediately, independent of clk; a later wrap causes no change.
- AUTO_SCAN_EN, SCAN_PERIODS=4: press key_scan -> scan_active=1; OutMode steps 01,10,11,00,01 on every 4th wrap. A key_mode press -> scan_active=0, then the normal pending commit.
